aes256_ctr_xcrypt: RTL

AES-256 counter-mode stream engine that drives the pipelined AES-256 core and turns its keystream into ciphertext (or plaintext; CTR is symmetric). It accepts 128-bit data beats on a valid/ready input, generates one counter block per beat into the core, delays each data beat to match the core latency, and XORs it with the core output. Backpressure on the output stalls the whole pipeline, including the core, through the core's enable.

---
 rtl/aes256_ctr_xcrypt_if.sv | 22 ++
 rtl/aes256_ctr_xcrypt.sv | 113 +++++++++++
 2 files changed

// File: rtl/aes256_ctr_xcrypt_if.sv
// Streaming data-in / data-out handshake bundle for the AES-256 CTR engine.
// The slave modport is the engine side; master is the producer/consumer side.
interface aes256_ctr_xcrypt_if;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/aes256_ctr_xcrypt.sv
// AES-256 CTR stream engine: feeds counter blocks to an external pipelined core
// and XORs the returned keystream with data delayed to match the core latency.
module aes256_ctr_xcrypt #(
    parameter int unsigned CORE_LATENCY = 29
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [255:0]         key,
    input  logic [127:0]         iv,
    output logic                 busy,
    output logic                 done,
    aes256_ctr_xcrypt_if.slave   io,
    output logic                 core_en,
    output logic [127:0]         core_state,
    output logic [255:0]         core_key,
    input  logic [127:0]         core_out
);
    localparam int unsigned TAIL = CORE_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [255:0]            key_q, key_d;
    logic [127:0]            ctr_q, ctr_d;
    logic [CORE_LATENCY-1:0] vld_q, vld_d;
    logic [CORE_LATENCY-1:0] lst_q, lst_d;
    logic [127:0]            dat_q [CORE_LATENCY];
    logic [127:0]            dat_d [CORE_LATENCY];
    logic                    accept;
    logic                    handoff;

    always_comb begin
        // Stall only when the tail is holding a beat the consumer refuses.
        core_en     = !(vld_q[TAIL] && !io.m_tready);
        io.s_tready = (state_q == RUN) && core_en;
        accept      = io.s_tready && io.s_tvalid;
        handoff     = vld_q[TAIL] && io.m_tready;
        io.m_tvalid = vld_q[TAIL];
        io.m_tlast  = vld_q[TAIL] && lst_q[TAIL];
        io.m_tdata  = vld_q[TAIL] ? (core_out ^ dat_q[TAIL]) : '0;
        core_state  = ctr_q;
        core_key    = key_q;
        busy        = (state_q != IDLE);
    end

    always_comb begin
        done    = 1'b0;
        state_d = state_q;
        key_d   = key_q;
        ctr_d   = ctr_q;
        vld_d   = vld_q;
        lst_d   = lst_q;
        dat_d   = dat_q;

        if (core_en) begin
            vld_d    = {vld_q[TAIL-1:0], accept};
            lst_d    = {lst_q[TAIL-1:0], accept && io.s_tlast};
            dat_d[0] = io.s_tdata;
            for (int unsigned i = 1; i < CORE_LATENCY; i++) begin
                dat_d[i] = dat_q[i-1];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    ctr_d   = iv;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    ctr_d = ctr_q + 128'd1;
                    if (io.s_tlast) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last beat is the youngest, so nothing may remain behind it.
                if (handoff && lst_q[TAIL] && !(|vld_q[TAIL-1:0])) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            ctr_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
            for (int unsigned i = 0; i < CORE_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ctr_q   <= ctr_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            for (int unsigned i = 0; i < CORE_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end
endmodule
